// File: rtl/arcade_input_pkg.sv
// Shared definitions for the arcade input mapper.
// Holds the keymap entry layout helpers, the scanner state enum,
// the PS/2 event bit positions and the captured key event type.
// A keymap entry is packed as
//   {valid, ext_any, scancode[8:0], player[PW-1:0], button[BW-1:0]}
// with button in the least significant bits.
package arcade_input_pkg;

  localparam int PS2_TOGGLE  = 10;
  localparam int PS2_PRESSED = 9;
  localparam int SCANCODE_W  = 9;

  typedef enum logic {
    IDLE,
    SCAN
  } scan_state_t;

  typedef struct packed {
    logic                  pressed;
    logic [SCANCODE_W-1:0] code;
  } key_event_t;

  // A single player still needs one bit so the player field never vanishes.
  function automatic int player_w(input int num_players);
    return (num_players > 1) ? $clog2(num_players) : 1;
  endfunction

  function automatic int button_w(input int num_btns);
    return $clog2(num_btns);
  endfunction

  function automatic int entry_w(input int pw, input int bw);
    return 2 + SCANCODE_W + pw + bw;
  endfunction

  function automatic int code_lsb(input int pw, input int bw);
    return pw + bw;
  endfunction

  function automatic int ext_bit(input int pw, input int bw);
    return pw + bw + SCANCODE_W;
  endfunction

  function automatic int valid_bit(input int pw, input int bw);
    return pw + bw + SCANCODE_W + 1;
  endfunction

endpackage

// File: rtl/input_pulse_stretch.sv
// Minimum-width stretcher for one coin line.
// A rising edge of the merged coin level (level high, registered copy low)
// loads the counter with COIN_PULSE; the counter then runs down to zero.
// active is high while the counter is non-zero and is ORed by the parent
// with its registered coin level, so a one-cycle pulse is held for exactly
// COIN_PULSE cycles. A new edge while counting reloads the full width.
// Ports:
//   clk_sys     system clock
//   reset_n     synchronous active-low reset, clears the counter
//   level       merged coin level (combinational, pre-register)
//   level_prev  registered copy of the same level held by the parent
//   active      counter non-zero
module input_pulse_stretch #(
  parameter logic [15:0] COIN_PULSE = 16'd4800
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic level,
  input  logic level_prev,
  output logic active
);

  logic [15:0] count;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      count <= '0;
    end else if (level && !level_prev) begin
      count <= COIN_PULSE;
    end else if (count != '0) begin
      count <= count - 16'd1;
    end
  end

  assign active = (count != '0);

endmodule

// File: rtl/arcade_input_mapper.sv
// Keyboard/joystick merge stage between hps_io and an arcade core.
// Each PS/2 key event (bit 10 toggles per event) is matched against every
// entry of a runtime-loadable keymap, one entry per cycle, and the matching
// buttons are set or released in a per-player held-button vector. That
// vector is ORed with the joystick inputs, registered, and each player's
// coin button is stretched to a minimum width.
// Ports:
//   clk_sys     system clock
//   reset_n     synchronous active-low reset (keymap contents survive it)
//   ps2_key     {toggle, pressed, scancode[8:0]} key event from hps_io
//   joy_in      joystick vectors, player 0 in the LSBs
//   map_wr      keymap write strobe
//   map_addr    keymap entry index
//   map_data    {valid, ext_any, scancode[8:0], player, button}
//   keys_clear  one-cycle pulse releasing all keyboard-held buttons
//   btn_out     registered merged, coin-stretched button vectors
//   busy        keymap scan in progress
//   overflow    sticky flag: a key event was dropped
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int          NUM_PLAYERS = 2,
  parameter int          NUM_BTNS    = 16,
  parameter int          MAP_DEPTH   = 32,
  parameter int          COIN_IDX    = 10,
  parameter logic [15:0] COIN_PULSE  = 16'd4800,
  localparam int         PW          = player_w(NUM_PLAYERS),
  localparam int         BW          = button_w(NUM_BTNS),
  localparam int         AW          = $clog2(MAP_DEPTH),
  localparam int         ENTRY_W     = entry_w(PW, BW),
  localparam int         VW          = NUM_PLAYERS * NUM_BTNS
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [10:0]        ps2_key,
  input  logic [VW-1:0]      joy_in,
  input  logic               map_wr,
  input  logic [AW-1:0]      map_addr,
  input  logic [ENTRY_W-1:0] map_data,
  input  logic               keys_clear,
  output logic [VW-1:0]      btn_out,
  output logic               busy,
  output logic               overflow
);

  localparam int          CODE_LSB  = code_lsb(PW, BW);
  localparam int          EXT_BIT   = ext_bit(PW, BW);
  localparam int          VALID_BIT = valid_bit(PW, BW);
  localparam logic [AW-1:0] LAST_IDX = AW'(MAP_DEPTH - 1);

  // Keymap storage is deliberately left out of reset so a core's mapping
  // survives a core reset. Power-up contents come from the FPGA
  // configuration (all zero, i.e. every entry invalid).
  logic [ENTRY_W-1:0] keymap [MAP_DEPTH];

  scan_state_t state, state_next;
  logic [AW-1:0] idx, idx_next;
  key_event_t    cur_evt, cur_evt_next;
  key_event_t    pend_evt, pend_evt_next;
  logic          pend_valid, pend_valid_next;
  logic          overflow_q, overflow_next;

  logic          toggle_q;
  logic          event_seen;
  key_event_t    new_evt;

  logic [ENTRY_W-1:0]    entry;
  logic [SCANCODE_W-1:0] ent_code;
  logic [PW-1:0]         ent_player;
  logic [BW-1:0]         ent_button;
  logic                  hit;

  logic [VW-1:0]          key_state, key_next;
  logic [VW-1:0]          merged, merged_q;
  logic [NUM_PLAYERS-1:0] coin_active;

  assign event_seen = ps2_key[PS2_TOGGLE] ^ toggle_q;
  assign new_evt    = {ps2_key[PS2_PRESSED], ps2_key[SCANCODE_W-1:0]};

  // The reset value of the toggle tracker is the live toggle bit, which is
  // exactly what the normal path loads, so no reset branch is needed.
  always_ff @(posedge clk_sys) begin
    toggle_q <= ps2_key[PS2_TOGGLE];
  end

  // Writes land on the next edge; a scan reading the same entry this cycle
  // therefore still sees the previous contents.
  always_ff @(posedge clk_sys) begin
    if (map_wr) begin
      keymap[map_addr] <= map_data;
    end
  end

  assign entry      = keymap[idx];
  assign ent_code   = entry[CODE_LSB +: SCANCODE_W];
  assign ent_player = entry[BW +: PW];
  assign ent_button = entry[BW-1:0];

  // ext_any lets one entry cover both the plain and the E0-prefixed code.
  assign hit = (state == SCAN) && entry[VALID_BIT] &&
               (ent_code[7:0] == cur_evt.code[7:0]) &&
               (entry[EXT_BIT] || (ent_code[8] == cur_evt.code[8]));

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx        <= '0;
      cur_evt    <= '0;
      pend_evt   <= '0;
      pend_valid <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      cur_evt    <= cur_evt_next;
      pend_evt   <= pend_evt_next;
      pend_valid <= pend_valid_next;
      overflow_q <= overflow_next;
    end
  end

  // The pending slot is always drained before a fresh event, so event order
  // is preserved; a fresh event arriving while the slot drains refills it.
  always_comb begin
    state_next      = state;
    idx_next        = idx;
    cur_evt_next    = cur_evt;
    pend_evt_next   = pend_evt;
    pend_valid_next = pend_valid;
    overflow_next   = overflow_q;
    case (state)
      IDLE: begin
        if (pend_valid) begin
          cur_evt_next = pend_evt;
          idx_next     = '0;
          state_next   = SCAN;
          if (event_seen) begin
            pend_evt_next = new_evt;
          end else begin
            pend_valid_next = 1'b0;
          end
        end else if (event_seen) begin
          cur_evt_next = new_evt;
          idx_next     = '0;
          state_next   = SCAN;
        end
      end
      SCAN: begin
        idx_next = idx + AW'(1);
        if (idx == LAST_IDX) begin
          state_next = IDLE;
        end
        if (event_seen) begin
          if (pend_valid) begin
            overflow_next = 1'b1;
          end else begin
            pend_evt_next   = new_evt;
            pend_valid_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Player or button fields beyond the configured counts match no loop
  // iteration and are thereby ignored.
  always_comb begin
    key_next = key_state;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      for (int b = 0; b < NUM_BTNS; b++) begin
        if (hit && (ent_player == p[PW-1:0]) && (ent_button == b[BW-1:0])) begin
          key_next[p*NUM_BTNS + b] = cur_evt.pressed;
        end
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n || keys_clear) begin
      key_state <= '0;
    end else begin
      key_state <= key_next;
    end
  end

  assign merged = key_state | joy_in;

  // Loading joy_in on reset keeps btn_out equal to the joysticks during and
  // right after reset, and avoids a false coin edge on release.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      merged_q <= joy_in;
    end else begin
      merged_q <= merged;
    end
  end

  for (genvar gp = 0; gp < NUM_PLAYERS; gp++) begin : g_coin
    input_pulse_stretch #(
      .COIN_PULSE(COIN_PULSE)
    ) u_stretch (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .level     (merged[gp*NUM_BTNS + COIN_IDX]),
      .level_prev(merged_q[gp*NUM_BTNS + COIN_IDX]),
      .active    (coin_active[gp])
    );
  end

  always_comb begin
    btn_out = merged_q;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      btn_out[p*NUM_BTNS + COIN_IDX] = merged_q[p*NUM_BTNS + COIN_IDX] | coin_active[p];
    end
  end

  assign busy     = (state == SCAN);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Self-checking bench for arcade_input_mapper with default parameters.
// A behavioural model (event queue, keymap array, coin deadlines) predicts
// btn_out/busy/overflow every cycle; directed sequences add literal checks.
module tb_arcade_input_mapper;

  localparam int NP = 2;
  localparam int NB = 16;
  localparam int MD = 32;
  localparam int CI = 10;
  localparam int CP = 4800;
  localparam int PW = 1;
  localparam int BW = 4;
  localparam int EW = 16;
  localparam int VW = NP * NB;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic [10:0]   ps2_key = '0;
  logic [VW-1:0] joy_in = '0;
  logic          map_wr = 1'b0;
  logic [4:0]    map_addr = '0;
  logic [EW-1:0] map_data = '0;
  logic          keys_clear = 1'b0;
  logic [VW-1:0] btn_out;
  logic          busy;
  logic          overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk_sys = ~clk_sys;

  arcade_input_mapper #(
    .NUM_PLAYERS(NP),
    .NUM_BTNS   (NB),
    .MAP_DEPTH  (MD),
    .COIN_IDX   (CI),
    .COIN_PULSE (16'd4800)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_key   (ps2_key),
    .joy_in    (joy_in),
    .map_wr    (map_wr),
    .map_addr  (map_addr),
    .map_data  (map_data),
    .keys_clear(keys_clear),
    .btn_out   (btn_out),
    .busy      (busy),
    .overflow  (overflow)
  );

  // ---------------- behavioural model ----------------
  logic [EW-1:0] m_map [MD];
  logic [VW-1:0] m_key = '0;
  logic [VW-1:0] m_merged_q = '0;
  bit            m_scanning = 1'b0;
  int            m_pos = 0;
  logic [9:0]    m_cur = '0;
  logic [9:0]    m_pend [$];
  bit            m_overflow = 1'b0;
  logic          m_tog = 1'b0;
  longint        m_cycle = 0;
  longint        m_coin_until [NP];
  bit            model_ready = 1'b0;

  function automatic logic [EW-1:0] mkEntry(input logic valid, input logic ext,
                                            input logic [8:0] code, input logic [PW-1:0] player,
                                            input logic [BW-1:0] button);
    return {valid, ext, code, player, button};
  endfunction

  function automatic bit entryHits(input logic [EW-1:0] e, input logic [9:0] ev);
    logic [8:0] code;
    code = e[EW-3 -: 9];
    if (!e[EW-1]) return 1'b0;
    if (code[7:0] != ev[7:0]) return 1'b0;
    return e[EW-2] || (code[8] == ev[8]);
  endfunction

  initial begin
    for (int i = 0; i < MD; i++) m_map[i] = '0;
    for (int p = 0; p < NP; p++) m_coin_until[p] = 0;
  end

  always @(posedge clk_sys) begin
    logic [VW-1:0] merged;
    logic          ev;
    logic [9:0]    nev;
    logic [EW-1:0] e;
    int            player;
    int            button;
    m_cycle++;
    merged = m_key | joy_in;
    ev     = (ps2_key[10] != m_tog);
    nev    = ps2_key[9:0];
    if (!reset_n) begin
      m_key      = '0;
      m_merged_q = joy_in;
      m_scanning = 1'b0;
      m_pos      = 0;
      m_pend.delete();
      m_overflow = 1'b0;
      m_tog      = ps2_key[10];
      for (int p = 0; p < NP; p++) m_coin_until[p] = 0;
      model_ready = 1'b1;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (merged[p*NB + CI] && !m_merged_q[p*NB + CI]) m_coin_until[p] = m_cycle + CP;
      end
      m_merged_q = merged;
      m_tog = ps2_key[10];
      if (m_scanning) begin
        e = m_map[m_pos];
        player = int'(e[BW +: PW]);
        button = int'(e[BW-1:0]);
        if (entryHits(e, m_cur) && player < NP && button < NB)
          m_key[player*NB + button] = m_cur[9];
        m_pos++;
        if (m_pos == MD) m_scanning = 1'b0;
        if (ev) begin
          if (m_pend.size() != 0) m_overflow = 1'b1;
          else m_pend.push_back(nev);
        end
      end else if (m_pend.size() != 0) begin
        m_cur = m_pend.pop_front();
        m_scanning = 1'b1;
        m_pos = 0;
        if (ev) m_pend.push_back(nev);
      end else if (ev) begin
        m_cur = nev;
        m_scanning = 1'b1;
        m_pos = 0;
      end
      if (keys_clear) m_key = '0;
    end
    if (map_wr) m_map[map_addr] = map_data;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk_sys) begin
    logic [VW-1:0] exp_btn;
    if (model_ready) begin
      exp_btn = m_merged_q;
      for (int p = 0; p < NP; p++) begin
        if (m_cycle < m_coin_until[p]) exp_btn[p*NB + CI] = 1'b1;
      end
      checkOutput("model_btn_out", btn_out, exp_btn);
      checkOutput("model_busy", {31'd0, busy}, {31'd0, m_scanning});
      checkOutput("model_overflow", {31'd0, overflow}, {31'd0, m_overflow});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic applyStimulus(input logic pressed, input logic [8:0] code);
    ps2_key = {~ps2_key[10], pressed, code};
    @(negedge clk_sys);
  endtask

  task automatic writeEntry(input int addr, input logic [EW-1:0] data);
    map_wr   = 1'b1;
    map_addr = 5'(addr);
    map_data = data;
    @(negedge clk_sys);
    map_wr = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_sys);
  endtask

  logic [8:0] codes [8];

  initial begin
    int cnt;
    int high;
    codes = '{9'h075, 9'h175, 9'h016, 9'h116, 9'h01c, 9'h11c, 9'h023, 9'h005};

    // Reset while filling the table with invalid entries.
    reset_n = 1'b0;
    for (int i = 0; i < MD; i++) writeEntry(i, '0);
    reset_n = 1'b1;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("reset_btn_out", btn_out, 32'd0);

    // Entry 0: ext_any key 75 -> P0 B3; 32-cycle scan.
    writeEntry(0, mkEntry(1'b1, 1'b1, 9'h075, 1'b0, 4'd3));
    applyStimulus(1'b1, 9'h175);
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk_sys);
    end
    checkOutput("scan_len", cnt, 32'd32);
    @(negedge clk_sys);
    checkOutput("press_btn3", {31'd0, btn_out[3]}, 32'd1);
    applyStimulus(1'b0, 9'h175);
    waitCycles(36);
    checkOutput("release_btn3", {31'd0, btn_out[3]}, 32'd0);

    // Entry 5: exact-ext key 16 -> P1 B8 (bit 24).
    writeEntry(5, mkEntry(1'b1, 1'b0, 9'h016, 1'b1, 4'd8));
    applyStimulus(1'b1, 9'h116);
    waitCycles(36);
    checkOutput("ext_mismatch_btn24", {31'd0, btn_out[24]}, 32'd0);
    applyStimulus(1'b1, 9'h016);
    waitCycles(36);
    checkOutput("ext_match_btn24", {31'd0, btn_out[24]}, 32'd1);

    // Three back-to-back events: scan, pend, drop.
    writeEntry(1, mkEntry(1'b1, 1'b0, 9'h01c, 1'b0, 4'd0));
    writeEntry(2, mkEntry(1'b1, 1'b0, 9'h01b, 1'b0, 4'd1));
    writeEntry(3, mkEntry(1'b1, 1'b0, 9'h023, 1'b0, 4'd2));
    applyStimulus(1'b1, 9'h01c);
    applyStimulus(1'b1, 9'h01b);
    applyStimulus(1'b1, 9'h023);
    waitCycles(80);
    checkOutput("burst_overflow", {31'd0, overflow}, 32'd1);
    checkOutput("burst_bits", {29'd0, btn_out[2:0]}, 32'd3);

    // Single-cycle coin pulse, then a retrigger 2000 cycles after the first.
    for (int run = 0; run < 2; run++) begin
      joy_in[CI] = 1'b1;
      @(negedge clk_sys);
      high = 0;
      for (int n = 1; n < 8000; n++) begin
        if (btn_out[CI]) high++;
        joy_in[CI] = (run == 1 && n == 2000);
        @(negedge clk_sys);
      end
      joy_in[CI] = 1'b0;
      checkOutput(run == 0 ? "coin_width" : "coin_retrigger_width", high,
                  run == 0 ? 32'd4800 : 32'd6800);
    end

    // Joystick passthrough, then keys_clear during a scan.
    joy_in = 32'h0000_0002;
    @(negedge clk_sys);
    checkOutput("joy_btn1", {31'd0, btn_out[1]}, 32'd1);
    applyStimulus(1'b1, 9'h005);
    waitCycles(5);
    keys_clear = 1'b1;
    @(negedge clk_sys);
    keys_clear = 1'b0;
    waitCycles(40);
    checkOutput("keys_clear_btn_out", btn_out, 32'h0000_0002);

    // Reset in the middle of a scan; table must survive.
    applyStimulus(1'b1, 9'h01c);
    waitCycles(5);
    reset_n = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    checkOutput("midscan_reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midscan_reset_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("midscan_reset_btn_out", btn_out, 32'h0000_0002);
    applyStimulus(1'b1, 9'h016);
    waitCycles(36);
    checkOutput("table_survives_btn24", {31'd0, btn_out[24]}, 32'd1);

    // Randomised traffic checked by the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0)
        ps2_key = {~ps2_key[10], 1'($urandom_range(1)), codes[$urandom_range(7)]};
      map_wr = ($urandom_range(31) == 0);
      map_addr = 5'($urandom_range(MD - 1));
      map_data = mkEntry(($urandom_range(3) != 0), 1'($urandom_range(1)), codes[$urandom_range(7)],
                         1'($urandom_range(1)), 4'($urandom_range(15)));
      keys_clear = ($urandom_range(63) == 0);
      if ($urandom_range(15) == 0) begin
        joy_in = $urandom();
        joy_in[CI] = ($urandom_range(3) == 0);
        joy_in[NB + CI] = ($urandom_range(3) == 0);
      end
      reset_n = ($urandom_range(599) != 0);
      @(negedge clk_sys);
    end
    map_wr = 1'b0;
    keys_clear = 1'b0;
    reset_n = 1'b1;
    waitCycles(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/arcade_input_mapper.md
Name: arcade_input_mapper

Overview:
- Parametrised successor to the fixed per-core keyboard/joystick merge logic.
- Decodes 11-bit PS/2 key events (bit 10 toggle, bit 9 pressed, bits 8:0 scancode) against a runtime-loadable keymap table.
- Keeps per-player held-button state, ORs it with the joystick vectors, and stretches coin pulses to a guaranteed minimum width.
- Sits between hps_io and the core in every arcade top level.

Parameters:
- NUM_PLAYERS, 2, number of player button vectors (1..4).
- NUM_BTNS, 16, buttons per player; equals joystick vector width.
- MAP_DEPTH, 32, keymap entries (power of two, 4..64).
- COIN_IDX, 10, button index treated as coin in every player vector.
- COIN_PULSE, 16'd4800, minimum coin high time in clk_sys cycles (≥1).

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- ps2_key  in  11  hps_io key event; bit 10 toggles once per event.
- joy_in  in  NUM_PLAYERS*NUM_BTNS  joystick vectors, player 0 in LSBs.
- map_wr  in  1  keymap write strobe.
- map_addr  in  $clog2(MAP_DEPTH)  keymap entry index.
- map_data  in  ENTRY_W  {valid, ext_any, scancode[8:0], player[PW-1:0], button[BW-1:0]}.
- keys_clear  in  1  one-cycle pulse that releases all keyboard-held buttons.
- btn_out  out  NUM_PLAYERS*NUM_BTNS  merged, coin-stretched button vectors.
- busy  out  1  table scan in progress.
- overflow  out  1  sticky: a key event was dropped.

Width definitions:
- PW = max(1, $clog2(NUM_PLAYERS)); BW = $clog2(NUM_BTNS); ENTRY_W = 11+PW+BW.

Behaviour:
- Reset (reset_n=0 at a clk_sys edge) clears: key_state, the pending slot, the FSM (to IDLE), coin counters, overflow, and the toggle tracker (loaded from the current ps2_key[10]).
- Outputs after reset: btn_out = joy_in, busy=0, overflow=0.
- The keymap table is NOT reset; contents survive reset. Power-up contents are all-invalid.
- Event detect: ps2_key[10] differing from the registered copy is one event; capture {pressed, scancode} the same cycle.
- FSM IDLE:
  - Event, or pending slot full → load the index counter with 0, go to SCAN.
  - Take the event from the pending slot first; a new event arriving the same cycle then goes into the pending slot.
- FSM SCAN:
  - Read one entry per cycle at index i.
  - Match when valid=1, entry code[7:0]=event code[7:0], and (ext_any=1 or code[8] equal).
  - On a match set key_state[player*NUM_BTNS+button] := pressed.
  - Player indices ≥ NUM_PLAYERS are ignored.
  - All entries are scanned, so one key may drive several buttons.
  - After index MAP_DEPTH-1, return to IDLE. Scan latency is exactly MAP_DEPTH cycles; busy=1 throughout SCAN.
- Events arriving during SCAN go to the one-deep pending slot.
  - Slot already full → drop the newest event and set overflow (cleared only by reset).
- Table writes are accepted in any state and take effect on the next cycle. A scan reading the entry being written that cycle sees the old value.
- keys_clear: clears key_state the same edge. It has priority over a scan update in that cycle; the scan continues.
- Merge: merged = key_state | joy_in, combinational into the stretch stage.
- Coin stretch, per player:
  - A rising edge of merged[COIN_IDX] loads the counter with COIN_PULSE.
  - btn_out coin bit = merged bit OR (counter≠0); the counter decrements to 0.
  - A retrigger while counting reloads the counter.
- Net latency: btn_out is registered, 1 cycle after key_state/joy_in change.
- Non-coin bits: btn_out = registered merged value.

Decomposition:
- Package arcade_input_pkg: entry field offsets/width functions, state enum {IDLE, SCAN}, PS2_TOGGLE/PRESSED bit constants.
- One sub-module: input_pulse_stretch (one counter, COIN_PULSE parameter), instantiated per player.

Test Plan:
- Entry 0 = {1,1,9'h075,P0,B3}; toggle ps2_key with pressed=1, code 'h175 → busy for 32 cycles, then btn_out[3]=1. Release event → btn_out[3]=0.
- Entry 5 = {1,0,9'h016,P1,B8}; send code 'h116 → no change (ext mismatch). Send 'h016 → btn_out[24]=1.
- Three events in consecutive cycles → first scanned, second pending, third dropped, overflow=1. Resulting state reflects events 1 and 2 only.
- Press mapped to P0 COIN_IDX for 1 cycle, COIN_PULSE=4800 → btn_out[10] high exactly 4800 cycles after the 1-cycle register latency. Retrigger at cycle 2000 → extends to 6800.
- joy_in[1]=1 while key_state empty → btn_out[1]=1 next cycle. keys_clear during an active scan → key_state 0, joystick bits unaffected.
- Reset mid-SCAN with entry table loaded → busy=0, btn_out=joy_in, overflow=0. A subsequent key event still matches the previously loaded entries.
